// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Holds the FSM state encoding, counter widths and an index-width helper.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_ABORT   = 2'd2
  } arb_state_e;

  localparam int OUTST_W = 3;
  localparam int WDOG_W  = 16;

  // Width of a master index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational cyclic-priority picker: grants the first requester after
// last_i, wrapping around, as a one-hot vector (all-zero if nobody requests).
module rr_picker
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    grant_o  = '0;
    cand     = 0;
    cand_idx = '0;
    found    = 1'b0;
    // Scan last+1 .. last+NUM_REQ so the previous owner has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Wishbone N:1 arbiter with round-robin grant, outstanding-transfer limit,
// and a stall watchdog that errors the owner and aborts a hung bus cycle.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         i_wb_clk,
  input  logic                         i_wb_rst_n,
  input  logic [NUM_MASTERS-1:0]       i_m_cyc,
  input  logic [NUM_MASTERS-1:0]       i_m_stb,
  input  logic [NUM_MASTERS-1:0]       i_m_we,
  input  logic [NUM_MASTERS-1:0][31:0] i_m_addr,
  input  logic [NUM_MASTERS-1:0][31:0] i_m_dat,
  input  logic [NUM_MASTERS-1:0][3:0]  i_m_sel,
  output logic [NUM_MASTERS-1:0]       o_m_ack,
  output logic [NUM_MASTERS-1:0]       o_m_err,
  output logic [NUM_MASTERS-1:0]       o_m_stall,
  output logic [31:0]                  o_m_dat,
  output logic                         o_s_cyc,
  output logic                         o_s_stb,
  output logic                         o_s_we,
  output logic [31:0]                  o_s_addr,
  output logic [31:0]                  o_s_dat,
  output logic [3:0]                   o_s_sel,
  input  logic [31:0]                  i_s_dat,
  input  logic                         i_s_ack,
  input  logic                         i_s_stall,
  input  logic                         i_s_err,
  output logic [NUM_MASTERS-1:0]       o_grant
);

  localparam int                 IDX_W      = idx_width(NUM_MASTERS);
  localparam logic [OUTST_W-1:0] MAX_OUT    = OUTST_W'(MAX_OUTSTANDING);
  localparam logic [WDOG_W-1:0]  WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_RST   = IDX_W'(NUM_MASTERS - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   full, rsp, accept, dec, timeout;

  rr_picker #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (i_m_cyc),
    .last_i  (last_owner_q),
    .grant_o (pick_grant)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (pick_grant[k]) pick_idx = IDX_W'(k);
    end
  end

  assign o_m_dat = i_s_dat;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    outst_d      = outst_q;
    wdog_d       = wdog_q;
    o_s_cyc      = 1'b0;
    o_s_stb      = 1'b0;
    o_s_we       = 1'b0;
    o_s_addr     = '0;
    o_s_dat      = '0;
    o_s_sel      = '0;
    o_m_ack      = '0;
    o_m_err      = '0;
    o_m_stall    = '1;
    o_grant      = '0;
    full         = (outst_q == MAX_OUT);
    rsp          = i_s_ack | i_s_err;
    accept       = 1'b0;
    dec          = 1'b0;
    timeout      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|i_m_cyc) begin
          owner_d = pick_idx;
          state_d = ST_GRANTED;
        end
      end

      ST_GRANTED: begin
        o_grant[owner_q]   = 1'b1;
        o_s_cyc            = i_m_cyc[owner_q];
        o_s_stb            = i_m_stb[owner_q] & ~full;
        o_s_we             = i_m_we[owner_q];
        o_s_addr           = i_m_addr[owner_q];
        o_s_dat            = i_m_dat[owner_q];
        o_s_sel            = i_m_sel[owner_q];
        o_m_stall[owner_q] = i_s_stall | full;
        o_m_ack[owner_q]   = i_s_ack;
        // A real ack/err in the limit cycle suppresses the watchdog error.
        timeout            = (outst_q != '0) && !rsp && (wdog_q == WDOG_LIMIT);
        o_m_err[owner_q]   = i_s_err | timeout;

        accept = o_s_stb & ~i_s_stall;
        dec    = rsp && (outst_q != '0);
        if (accept && !dec)      outst_d = outst_q + OUTST_W'(1);
        else if (!accept && dec) outst_d = outst_q - OUTST_W'(1);
        wdog_d = ((outst_q == '0) || rsp) ? '0 : wdog_q + WDOG_W'(1);

        if (!i_m_cyc[owner_q]) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          outst_d      = '0;
          wdog_d       = '0;
        end else if (timeout) begin
          state_d = ST_ABORT;
          outst_d = '0;
          wdog_d  = '0;
        end
      end

      ST_ABORT: begin
        o_grant[owner_q] = 1'b1;
        state_d          = ST_IDLE;
        last_owner_d     = owner_q;
        outst_d          = '0;
        wdog_d           = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is asynchronous and takes effect immediately.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      outst_q      <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      outst_q      <= outst_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (2 masters, timeout 8, max 4
// outstanding): a combinational vector table plus multi-cycle sequences.
module tb_wb_arbiter;

  localparam int NM = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NM-1:0]       m_cyc, m_stb, m_we;
  logic [NM-1:0][31:0] m_addr, m_dat;
  logic [NM-1:0][3:0]  m_sel;
  logic [NM-1:0]       m_ack, m_err, m_stall, grant;
  logic [31:0]         m_rdat, s_addr, s_wdat, s_rdat;
  logic                s_cyc, s_stb, s_we, s_ack, s_stall, s_err;
  logic [3:0]          s_sel;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  cyc, stb, we;
    logic        ack, err, stall;
    logic [31:0] dat;
    logic        e_cyc, e_stb, e_we;
    logic [1:0]  e_ack, e_err, e_stall;
  } vec_t;

  vec_t vecs[6];

  wb_arbiter #(
    .NUM_MASTERS     (NM),
    .TIMEOUT_CYCLES  (8),
    .MAX_OUTSTANDING (4)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_m_cyc    (m_cyc),
    .i_m_stb    (m_stb),
    .i_m_we     (m_we),
    .i_m_addr   (m_addr),
    .i_m_dat    (m_dat),
    .i_m_sel    (m_sel),
    .o_m_ack    (m_ack),
    .o_m_err    (m_err),
    .o_m_stall  (m_stall),
    .o_m_dat    (m_rdat),
    .o_s_cyc    (s_cyc),
    .o_s_stb    (s_stb),
    .o_s_we     (s_we),
    .o_s_addr   (s_addr),
    .o_s_dat    (s_wdat),
    .o_s_sel    (s_sel),
    .i_s_dat    (s_rdat),
    .i_s_ack    (s_ack),
    .i_s_stall  (s_stall),
    .i_s_err    (s_err),
    .o_grant    (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int issued, acked, outst, saw_full, exp_stb;
    int acc_cyc[6];

    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_dat = '0; m_sel = '0;
    s_rdat = 32'hDEAD_BEEF; s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;

    vecs[0] = '{2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10};
    vecs[1] = '{2'b11, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 32'hA5A5_0002, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10};
    vecs[2] = '{2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 32'hA5A5_0003, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b11};
    vecs[3] = '{2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 32'hA5A5_0004, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b10};
    vecs[4] = '{2'b01, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 32'hA5A5_0005, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 2'b11};
    vecs[5] = '{2'b11, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1, 32'hA5A5_0006, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b11};

    // Reset values, with read data broadcast even while idle.
    #2;
    check("rst_grant", 32'(grant), 0);
    check("rst_s_cyc", 32'(s_cyc), 0);
    check("rst_stall", 32'(m_stall), 3);
    check("rst_ack_err", 32'({m_ack, m_err}), 0);
    check("idle_m_dat", m_rdat, 32'hDEAD_BEEF);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Master 0 single read from the GPIO slave.
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00; m_addr[0] = 32'h4001_0000; m_sel[0] = 4'hF;
    #1;
    check("a_idle_grant", 32'(grant), 0);
    check("a_idle_stall", 32'(m_stall), 3);
    tick();
    check("a_grant", 32'(grant), 1);
    check("a_s_addr", s_addr, 32'h4001_0000);
    check("a_s_stb", 32'(s_stb), 1);
    check("a_stall", 32'(m_stall), 2);
    tick();
    m_stb = 2'b00; s_ack = 1'b1; s_rdat = 32'h0001_0000;
    #1;
    check("a_ack", 32'(m_ack), 1);
    check("a_rdata", m_rdat, 32'h0001_0000);
    tick();
    s_ack = 1'b0; m_cyc = 2'b00;
    #1;
    check("a_s_cyc_drop", 32'(s_cyc), 0);
    tick();
    check("a_back_idle", 32'(grant), 0);

    // Combinational mirroring table with master 0 owning the bus.
    m_cyc = 2'b01;
    tick();
    check("t_grant", 32'(grant), 1);
    for (int i = 0; i < 6; i++) begin
      m_cyc = vecs[i].cyc; m_stb = vecs[i].stb; m_we = vecs[i].we;
      s_ack = vecs[i].ack; s_err = vecs[i].err; s_stall = vecs[i].stall; s_rdat = vecs[i].dat;
      m_addr[0] = 32'h1000_0000 + 32'(i); m_addr[1] = 32'h2000_0000 + 32'(i);
      m_sel[0] = 4'(i + 1); m_sel[1] = 4'hF;
      #1;
      check($sformatf("t%0d_s_cyc", i), 32'(s_cyc), 32'(vecs[i].e_cyc));
      check($sformatf("t%0d_s_stb", i), 32'(s_stb), 32'(vecs[i].e_stb));
      check($sformatf("t%0d_s_we", i), 32'(s_we), 32'(vecs[i].e_we));
      check($sformatf("t%0d_ack", i), 32'(m_ack), 32'(vecs[i].e_ack));
      check($sformatf("t%0d_err", i), 32'(m_err), 32'(vecs[i].e_err));
      check($sformatf("t%0d_stall", i), 32'(m_stall), 32'(vecs[i].e_stall));
      check($sformatf("t%0d_addr", i), s_addr, 32'h1000_0000 + 32'(i));
      check($sformatf("t%0d_sel", i), 32'(s_sel), 32'(i + 1));
      check($sformatf("t%0d_m_dat", i), m_rdat, vecs[i].dat);
    end
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
    tick();

    // Fresh reset so master 0 wins first, then four simultaneous contests.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_addr[0] = 32'h0000_0100; m_addr[1] = 32'h0000_0200;
    for (int r = 0; r < 4; r++) begin
      m_cyc = 2'b11; m_stb = 2'b11;
      #1;
      check($sformatf("b%0d_idle", r), 32'(grant), 0);
      tick();
      check($sformatf("b%0d_grant", r), 32'(grant), (r % 2 == 0) ? 1 : 2);
      check($sformatf("b%0d_addr", r), s_addr, (r % 2 == 0) ? 32'h100 : 32'h200);
      check($sformatf("b%0d_stall", r), 32'(m_stall), (r % 2 == 0) ? 2 : 1);
      tick();
      m_stb = 2'b00; s_ack = 1'b1;
      #1;
      check($sformatf("b%0d_ack", r), 32'(m_ack), (r % 2 == 0) ? 1 : 2);
      tick();
      s_ack = 1'b0; m_cyc = 2'b00;
      tick();
    end

    // Master 1 pipelined writes; slave acks with three dead cycles.
    m_cyc = 2'b10; m_we = 2'b10; m_addr[1] = 32'h4001_0024; m_sel[1] = 4'hF;
    tick();
    check("c_grant", 32'(grant), 2);
    issued = 0; acked = 0; outst = 0; saw_full = 0;
    for (int c = 0; c < 40 && acked < 6; c++) begin
      m_stb[1] = (issued < 6);
      m_dat[1] = 32'hC0DE_0000 + 32'(issued);
      s_ack = (acked < issued) && (c == acc_cyc[acked] + 4);
      #1;
      exp_stb = (m_stb[1] && outst < 4) ? 1 : 0;
      check($sformatf("c%0d_stall", c), 32'(m_stall[1]), (outst == 4) ? 1 : 0);
      check($sformatf("c%0d_stb", c), 32'(s_stb), 32'(exp_stb));
      check($sformatf("c%0d_ack", c), 32'(m_ack), s_ack ? 2 : 0);
      if (exp_stb != 0) check($sformatf("c%0d_wdat", c), s_wdat, 32'hC0DE_0000 + 32'(issued));
      if (outst == 4) saw_full = 1;
      if (exp_stb != 0) begin
        acc_cyc[issued] = c;
        issued++;
      end
      if (s_ack) acked++;
      outst = outst + exp_stb - (s_ack ? 1 : 0);
      tick();
    end
    s_ack = 1'b0;
    check("c_all_acked", 32'(acked), 6);
    check("c_saw_full", 32'(saw_full), 1);
    check("c_outst_zero", 32'(dut.outst_q), 0);
    m_cyc = '0; m_stb = '0; m_we = '0;
    tick();

    // Slave never acks: watchdog error, one abort cycle, master 1 next.
    m_cyc = 2'b11; m_stb = 2'b01; m_addr[0] = 32'h4001_0008;
    tick();
    check("d_grant", 32'(grant), 1);
    check("d_s_stb", 32'(s_stb), 1);
    tick();
    m_stb = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check($sformatf("d_err_c%0d", k), 32'(m_err), (k == 8) ? 1 : 0);
      if (k < 8) tick();
    end
    tick();
    m_cyc = 2'b10;
    #1;
    check("d_abort_s_cyc", 32'(s_cyc), 0);
    check("d_abort_stall", 32'(m_stall), 3);
    check("d_abort_err", 32'(m_err), 0);
    tick();
    check("d_idle_grant", 32'(grant), 0);
    tick();
    check("d_other_grant", 32'(grant), 2);
    m_cyc = 2'b00;
    tick();

    // Ack lands in the watchdog's limit cycle: ack wins, bus stays granted.
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    check("e_grant", 32'(grant), 1);
    tick();
    m_stb = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      #1;
      check($sformatf("e_noerr_c%0d", k), 32'(m_err), 0);
      tick();
    end
    s_ack = 1'b1;
    #1;
    check("e_ack", 32'(m_ack), 1);
    check("e_no_err", 32'(m_err), 0);
    tick();
    s_ack = 1'b0;
    #1;
    check("e_still_granted", 32'(grant), 1);
    check("e_s_cyc", 32'(s_cyc), 1);
    check("e_wdog_clear", 32'(dut.wdog_q), 0);
    m_cyc = 2'b00;
    tick();

    // Asynchronous reset with two transfers outstanding.
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    check("f_grant", 32'(grant), 1);
    tick();
    tick();
    m_stb = 2'b00;
    #1;
    check("f_outst_two", 32'(dut.outst_q), 2);
    s_ack = 1'b1; m_cyc = 2'b11; rst_n = 1'b0;
    #1;
    check("f_rst_s_cyc", 32'(s_cyc), 0);
    check("f_rst_grant", 32'(grant), 0);
    check("f_rst_ack_err", 32'({m_ack, m_err}), 0);
    check("f_rst_stall", 32'(m_stall), 3);
    s_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("f_first_grant", 32'(grant), 1);
    m_cyc = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone masters sharing one slave (legal 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-transfer watchdog limit in clocks (1..65535).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, accepted-but-unacknowledged transfers allowed (1..7).
REQ-004 i_wb_clk  in  1  single clock; one clock; reset is asynchronous and active-low.
REQ-005 i_wb_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_m_cyc, i_m_stb, i_m_we  in  NUM_MASTERS each  per-master bus cycle, strobe and write enable.
REQ-007 i_m_addr, i_m_dat  in  NUM_MASTERS x 32  per-master address and write data; i_m_sel  in  NUM_MASTERS x 4  byte selects.
REQ-008 o_m_ack, o_m_err, o_m_stall  out  NUM_MASTERS each  per-master acknowledge, error and stall.
REQ-009 o_m_dat  out  32  slave read data, broadcast to all masters.
REQ-010 o_s_cyc, o_s_stb, o_s_we  out  1 each; o_s_addr, o_s_dat  out  32; o_s_sel  out  4  slave request.
REQ-011 i_s_dat  in  32; i_s_ack, i_s_stall, i_s_err  in  1 each  slave response.
REQ-012 o_grant  out  NUM_MASTERS  one-hot current owner, all-zero when unowned.

Function
REQ-013 SHALL implement states IDLE, GRANTED, ABORT.
REQ-014 IDLE: o_s_cyc=o_s_stb=0, all o_m_stall=1, o_m_ack=o_m_err=0; if any i_m_cyc set, SHALL grant the first requester after last_owner in cyclic index order and enter GRANTED next edge (1-cycle arbitration latency).
REQ-015 GRANTED: o_s_* SHALL combinationally mirror the owner's inputs; owner SHALL receive i_s_ack, i_s_err, i_s_stall; non-owners SHALL see stall=1, ack=0, err=0.
REQ-016 Owner stall SHALL additionally assert when outstanding==MAX_OUTSTANDING, and o_s_stb SHALL be masked to 0 in that case.
REQ-017 Outstanding counter SHALL increment on o_s_stb & ~i_s_stall, decrement on i_s_ack|i_s_err; both in one cycle leaves it unchanged.
REQ-018 When the owner drops i_m_cyc, SHALL return to IDLE next edge, set last_owner=owner and clear outstanding, even if transfers are outstanding (bus abort).
REQ-019 Watchdog SHALL count clocks with outstanding>0 and no ack/err, resetting on any ack/err or when outstanding==0.
REQ-020 On watchdog reaching TIMEOUT_CYCLES, SHALL pulse the owner's o_m_err for exactly one cycle and enter ABORT.
REQ-021 ABORT: o_s_cyc=0, owner stalled, for exactly one cycle, then IDLE with last_owner=owner and counters cleared.
REQ-022 Ack and timeout in the same cycle: ack SHALL win, no error, watchdog cleared.
REQ-023 Requests arriving while owned SHALL wait; no pre-emption; owner with permanent i_m_cyc holds the bus indefinitely.
REQ-024 o_m_dat SHALL equal i_s_dat in every state.

Reset
REQ-025 On i_wb_rst_n=0 (asynchronous): state=IDLE, o_grant=0, outstanding=0, watchdog=0, last_owner=NUM_MASTERS-1 so master 0 wins first; all outputs at IDLE values within the reset cycle.
REQ-026 Reset mid-transfer SHALL drop o_s_cyc immediately, with no ack/err to any master.

Structure
REQ-027 Package wb_arbiter_pkg SHALL hold the state enum and the counter-width constants (outstanding 3 bits, watchdog 16 bits).
REQ-028 Cyclic priority selection SHALL be a sub-module rr_picker (request vector, last_owner in; one-hot grant out; combinational).

Verification
REQ-029 Reset, master 0 reads 0x4001_0000 from the GPIO slave -> o_grant=01 one cycle after i_m_cyc, ack returns 0x0001_0000, IDLE after cyc drop.
REQ-030 Both masters assert cyc in the same cycle, repeated 4 times -> grants alternate 0,1,0,1; the waiting master sees stall=1 and never ack.
REQ-031 Master 1 issues 6 pipelined writes to 0x4001_0024 with slave ack delayed 3 cycles, MAX_OUTSTANDING=4 -> owner stalled at 4 outstanding, all 6 acked in order, counter returns 0.
REQ-032 Slave never acks, TIMEOUT_CYCLES=8 -> err pulse exactly 8 cycles after the last accepted stb, one ABORT cycle with o_s_cyc=0, other master granted next.
REQ-033 Ack on the same cycle the watchdog hits its limit -> ack delivered, no err, state stays GRANTED.
REQ-034 i_wb_rst_n asserted with 2 outstanding -> o_s_cyc=0 and o_grant=0 asynchronously, no ack/err issued; master 0 granted first after release.
